// File: rtl/motor_ctrl_pkg.sv
// Shared types for the per-axis motor command sequencer.
// State encodings, duty width and command saturation helper.
package motor_ctrl_pkg;

    localparam int DUTY_W = 16;

    typedef enum logic [1:0] {
        ST_SAFE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RAMP = 2'd2
    } mc_state_t;

    // Clamp a signed duty request to +/- lim
    function automatic logic signed [DUTY_W-1:0] sat_duty(
        input logic signed [DUTY_W-1:0] d,
        input logic signed [DUTY_W-1:0] lim
    );
        logic signed [DUTY_W-1:0] r;
        r = d;
        if (d > lim) begin
            r = lim;
        end else if (d < -lim) begin
            r = -lim;
        end
        return r;
    endfunction

endpackage

// File: rtl/duty_slew_step.sv
// One slew step of a signed duty value toward a target.
// Never crosses zero or overshoots the target in a single step.
module duty_slew_step
    import motor_ctrl_pkg::*;
(
    input  logic signed [DUTY_W-1:0] cur,
    input  logic signed [DUTY_W-1:0] tgt,
    input  logic        [DUTY_W-1:0] step,
    output logic signed [DUTY_W-1:0] next,
    output logic                     hit_zero_on_reversal
);

    logic signed [DUTY_W:0] w_cur;
    logic signed [DUTY_W:0] w_tgt;
    logic signed [DUTY_W:0] w_step;
    logic signed [DUTY_W:0] w_diff;
    logic signed [DUTY_W:0] w_res;
    logic                   w_rev;

    // Reversal drains toward zero first; otherwise approach the target
    always_comb begin
        w_cur  = {cur[DUTY_W-1], cur};
        w_tgt  = {tgt[DUTY_W-1], tgt};
        w_step = {1'b0, step};
        w_diff = w_tgt - w_cur;
        w_rev  = ((w_cur > 17'sd0) && (w_tgt < 17'sd0)) ||
                 ((w_cur < 17'sd0) && (w_tgt > 17'sd0));
        w_res  = w_cur;
        hit_zero_on_reversal = 1'b0;
        if (w_rev) begin
            if (w_cur > w_step) begin
                w_res = w_cur - w_step;
            end else if (w_cur < -w_step) begin
                w_res = w_cur + w_step;
            end else begin
                w_res = '0;
                hit_zero_on_reversal = 1'b1;
            end
        end else if (w_diff > w_step) begin
            w_res = w_cur + w_step;
        end else if (w_diff < -w_step) begin
            w_res = w_cur - w_step;
        end else begin
            w_res = w_tgt;
        end
        next = w_res[DUTY_W-1:0];
    end

endmodule

// File: rtl/motor_cmd_sequencer.sv
// Per-axis duty sequencer between the SPI slave and a PWM generator.
// Period-aligned slewing, reversal dead time and a ramp-down watchdog.
module motor_cmd_sequencer
    import motor_ctrl_pkg::*;
#(
    parameter int MAX_COUNT  = 4096,
    parameter int SLEW_STEP  = 64,
    parameter int DEAD_TICKS = 2,
    parameter int WDT_CYCLES = 5_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DUTY_W-1:0] cmd_duty,
    input  logic                     cmd_valid,
    input  logic                     period_tick,
    output logic signed [DUTY_W-1:0] duty_out,
    output logic        [1:0]        state,
    output logic                     wdt_trip,
    output logic                     at_target
);

    localparam int WDT_W  = $clog2(WDT_CYCLES + 1);
    localparam int DEAD_W = $clog2(DEAD_TICKS + 2);

    localparam logic [WDT_W-1:0]         WDT_LAST  = WDT_W'(WDT_CYCLES - 1);
    localparam logic signed [DUTY_W-1:0] DUTY_LIM  = DUTY_W'(MAX_COUNT - 1);
    localparam logic [DUTY_W-1:0]        STEP      = DUTY_W'(SLEW_STEP);
    localparam logic [DEAD_W-1:0]        DEAD_LOAD = DEAD_W'(DEAD_TICKS);

    mc_state_t                r_state;
    mc_state_t                w_state_nxt;
    logic signed [DUTY_W-1:0] r_target;
    logic signed [DUTY_W-1:0] w_target_nxt;
    logic signed [DUTY_W-1:0] r_duty;
    logic [WDT_W-1:0]         r_wdt_cnt;
    logic [WDT_W-1:0]         w_wdt_nxt;
    logic [DEAD_W-1:0]        r_dead_cnt;
    logic                     r_wdt_trip;
    logic                     w_trip_nxt;
    logic signed [DUTY_W-1:0] w_slew_next;
    logic                     w_hit_zero;

    duty_slew_step u_step (
        .cur                  (r_duty),
        .tgt                  (r_target),
        .step                 (STEP),
        .next                 (w_slew_next),
        .hit_zero_on_reversal (w_hit_zero)
    );

    // Mode, target and watchdog next-state decode
    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_wdt_nxt    = r_wdt_cnt;
        w_trip_nxt   = r_wdt_trip;
        unique case (r_state)
            ST_SAFE: begin
                w_target_nxt = '0;
                w_wdt_nxt    = '0;
                if (cmd_valid && (cmd_duty == '0)) begin
                    w_state_nxt = ST_RUN;
                    w_trip_nxt  = 1'b0;
                end
            end
            ST_RUN: begin
                if (cmd_valid) begin
                    w_target_nxt = sat_duty(cmd_duty, DUTY_LIM);
                    w_wdt_nxt    = '0;
                end else if (r_wdt_cnt >= WDT_LAST) begin
                    w_state_nxt  = ST_RAMP;
                    w_target_nxt = '0;
                    w_trip_nxt   = 1'b1;
                    w_wdt_nxt    = '0;
                end else begin
                    w_wdt_nxt = r_wdt_cnt + 1'b1;
                end
            end
            ST_RAMP: begin
                w_target_nxt = '0;
                w_wdt_nxt    = '0;
                if (r_duty == '0) begin
                    w_state_nxt = ST_SAFE;
                end
            end
            default: begin
                w_state_nxt  = ST_SAFE;
                w_target_nxt = '0;
                w_wdt_nxt    = '0;
            end
        endcase
    end

    // Mode register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_SAFE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Target, watchdog counter and sticky trip flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_target   <= '0;
            r_wdt_cnt  <= '0;
            r_wdt_trip <= 1'b0;
        end else begin
            r_target   <= w_target_nxt;
            r_wdt_cnt  <= w_wdt_nxt;
            r_wdt_trip <= w_trip_nxt;
        end
    end

    // Duty stepping on PWM period boundaries with reversal dead time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty     <= '0;
            r_dead_cnt <= '0;
        end else if (r_state == ST_SAFE) begin
            r_duty     <= '0;
            r_dead_cnt <= '0;
        end else if (period_tick) begin
            if (r_dead_cnt != '0) begin
                r_dead_cnt <= r_dead_cnt - 1'b1;
            end else begin
                r_duty <= w_slew_next;
                if (w_hit_zero) begin
                    r_dead_cnt <= DEAD_LOAD;
                end
            end
        end
    end

    assign duty_out  = r_duty;
    assign state     = r_state;
    assign wdt_trip  = r_wdt_trip;
    assign at_target = (r_duty == r_target);

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Self-checking bench for motor_cmd_sequencer.
// Table vectors, a small slew model and hand-built corner sequences.
module tb_motor_cmd_sequencer;

    localparam int S_SAFE = 0;
    localparam int S_RUN  = 1;
    localparam int S_RAMP = 2;

    logic               clk;
    logic               rst;
    logic signed [15:0] cmd_duty;
    logic               cmd_valid;
    logic               period_tick;
    logic signed [15:0] duty_out;
    logic        [1:0]  state;
    logic               wdt_trip;
    logic               at_target;

    motor_cmd_sequencer #(
        .MAX_COUNT  (4096),
        .SLEW_STEP  (64),
        .DEAD_TICKS (2),
        .WDT_CYCLES (1000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_duty    (cmd_duty),
        .cmd_valid   (cmd_valid),
        .period_tick (period_tick),
        .duty_out    (duty_out),
        .state       (state),
        .wdt_trip    (wdt_trip),
        .at_target   (at_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic               v;
        logic signed [15:0] d;
        int                 ed;
        int                 ea;
    } vec_t;

    typedef struct {
        string nm;
        int    duty;
        int    st;
        int    at;
    } exp_t;

    vec_t tbl [22];
    exp_t sbq [$];

    int n_chk  = 0;
    int n_pass = 0;
    int m_duty = 0;
    int m_tgt  = 0;
    int m_dead = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic cyc(input logic tk, input logic v, input logic signed [15:0] d);
        @(negedge clk);
        period_tick = tk;
        cmd_valid   = v;
        cmd_duty    = d;
        @(posedge clk);
        #1;
        period_tick = 1'b0;
        cmd_valid   = 1'b0;
    endtask

    task automatic push_exp(input string nm, input int ed, input int es, input int ea);
        exp_t e;
        e.nm   = nm;
        e.duty = ed;
        e.st   = es;
        e.at   = ea;
        sbq.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sbq.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = sbq.pop_front();
            chk({e.nm, "_duty"}, int'(duty_out), e.duty);
            chk({e.nm, "_state"}, int'(state), e.st);
            chk({e.nm, "_at"}, int'(at_target), e.at);
        end
    endtask

    // One PWM period: optional command first, tick on the 16th clk
    task automatic period(input logic v, input logic signed [15:0] d,
                          input int ed, input int es, input int ea,
                          input string nm);
        cyc(1'b0, v, d);
        repeat (14) cyc(1'b0, 1'b0, 16'sd0);
        push_exp(nm, ed, es, ea);
        cyc(1'b1, 1'b0, 16'sd0);
        check_out();
    endtask

    function automatic void m_step();
        if (m_dead > 0) begin
            m_dead--;
        end else if ((m_duty > 0 && m_tgt < 0) || (m_duty < 0 && m_tgt > 0)) begin
            if (m_duty > 64) m_duty -= 64;
            else if (m_duty < -64) m_duty += 64;
            else begin
                m_duty = 0;
                m_dead = 2;
            end
        end else if (m_tgt - m_duty > 64) begin
            m_duty += 64;
        end else if (m_tgt - m_duty < -64) begin
            m_duty -= 64;
        end else begin
            m_duty = m_tgt;
        end
    endfunction

    task automatic mperiod(input logic v, input logic signed [15:0] d, input string nm);
        if (v) begin
            if (d > 4095) m_tgt = 4095;
            else if (d < -4095) m_tgt = -4095;
            else m_tgt = int'(d);
        end
        m_step();
        period(v, d, m_duty, S_RUN, (m_duty == m_tgt) ? 1 : 0, nm);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{1'b1, 16'sd500, 64, 0};
        tbl[1]  = '{1'b0, 16'sd0, 128, 0};
        tbl[2]  = '{1'b0, 16'sd0, 192, 0};
        tbl[3]  = '{1'b0, 16'sd0, 256, 0};
        tbl[4]  = '{1'b0, 16'sd0, 320, 0};
        tbl[5]  = '{1'b0, 16'sd0, 384, 0};
        tbl[6]  = '{1'b0, 16'sd0, 448, 0};
        tbl[7]  = '{1'b0, 16'sd0, 500, 1};
        tbl[8]  = '{1'b1, -16'sd200, 436, 0};
        tbl[9]  = '{1'b0, 16'sd0, 372, 0};
        tbl[10] = '{1'b0, 16'sd0, 308, 0};
        tbl[11] = '{1'b0, 16'sd0, 244, 0};
        tbl[12] = '{1'b0, 16'sd0, 180, 0};
        tbl[13] = '{1'b0, 16'sd0, 116, 0};
        tbl[14] = '{1'b0, 16'sd0, 52, 0};
        tbl[15] = '{1'b0, 16'sd0, 0, 0};
        tbl[16] = '{1'b0, 16'sd0, 0, 0};
        tbl[17] = '{1'b0, 16'sd0, 0, 0};
        tbl[18] = '{1'b0, 16'sd0, -64, 0};
        tbl[19] = '{1'b0, 16'sd0, -128, 0};
        tbl[20] = '{1'b0, 16'sd0, -192, 0};
        tbl[21] = '{1'b0, 16'sd0, -200, 1};

        rst         = 1'b1;
        cmd_duty    = '0;
        cmd_valid   = 1'b0;
        period_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_duty", int'(duty_out), 0);
        chk("rst_state", int'(state), S_SAFE);
        chk("rst_trip", int'(wdt_trip), 0);
        chk("rst_at", int'(at_target), 1);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 16'sd0);
        chk("idle_state", int'(state), S_SAFE);

        // Arm, ramp to 500, then reverse to -200
        cyc(1'b0, 1'b1, 16'sd0);
        chk("arm_state", int'(state), S_RUN);
        for (int i = 0; i < 22; i++) begin
            period(tbl[i].v, tbl[i].d, tbl[i].ed, S_RUN, tbl[i].ea,
                   $sformatf("tbl%0d", i));
        end

        // Saturation both ways, tracked by the model
        m_duty = -200;
        m_tgt  = -200;
        m_dead = 0;
        for (int i = 0; i < 200 && m_duty != 4095; i++) mperiod(1'b1, 16'sd9000, "sat_pos");
        chk("sat_pos_reach", int'(duty_out), 4095);
        mperiod(1'b1, 16'sd9000, "sat_pos_hold");
        chk("sat_pos_at", int'(at_target), 1);
        for (int i = 0; i < 200 && m_duty != -4095; i++) mperiod(1'b1, -16'sd9000, "sat_neg");
        chk("sat_neg_reach", int'(duty_out), -4095);
        mperiod(1'b1, -16'sd9000, "sat_neg_hold");
        chk("sat_neg_at", int'(at_target), 1);

        // Watchdog from duty 300
        for (int i = 0; i < 100 && m_duty != 300; i++) mperiod(1'b1, 16'sd300, "to300");
        chk("at300", int'(duty_out), 300);
        cyc(1'b0, 1'b1, 16'sd300);
        repeat (990) cyc(1'b0, 1'b0, 16'sd0);
        chk("wdt_pre_state", int'(state), S_RUN);
        chk("wdt_pre_trip", int'(wdt_trip), 0);
        repeat (12) cyc(1'b0, 1'b0, 16'sd0);
        chk("wdt_state", int'(state), S_RAMP);
        chk("wdt_trip", int'(wdt_trip), 1);
        chk("wdt_frozen", int'(duty_out), 300);
        chk("wdt_at", int'(at_target), 0);
        period(1'b1, 16'sd700, 236, S_RAMP, 0, "ramp0");
        period(1'b0, 16'sd0, 172, S_RAMP, 0, "ramp1");
        period(1'b0, 16'sd0, 108, S_RAMP, 0, "ramp2");
        period(1'b0, 16'sd0, 44, S_RAMP, 0, "ramp3");
        period(1'b0, 16'sd0, 0, S_RAMP, 1, "ramp4");
        cyc(1'b0, 1'b0, 16'sd0);
        chk("safe_state", int'(state), S_SAFE);
        cyc(1'b0, 1'b1, 16'sd700);
        chk("safe_ign_state", int'(state), S_SAFE);
        chk("safe_ign_trip", int'(wdt_trip), 1);
        period(1'b0, 16'sd0, 0, S_SAFE, 1, "safe_hold");
        cyc(1'b0, 1'b1, 16'sd0);
        chk("rearm_state", int'(state), S_RUN);
        chk("rearm_trip", int'(wdt_trip), 0);

        // Command on the last watchdog clk keeps RUN
        repeat (999) cyc(1'b0, 1'b0, 16'sd0);
        cyc(1'b0, 1'b1, 16'sd0);
        chk("race_wdt_state", int'(state), S_RUN);
        repeat (5) cyc(1'b0, 1'b0, 16'sd0);
        chk("race_wdt_after", int'(state), S_RUN);
        chk("race_wdt_trip", int'(wdt_trip), 0);

        // Command coincident with tick steps toward the old target
        push_exp("race_tick", 0, S_RUN, 0);
        cyc(1'b1, 1'b1, 16'sd200);
        check_out();
        period(1'b0, 16'sd0, 64, S_RUN, 0, "race_next");

        // Async reset mid-ramp at -320
        m_duty = 64;
        m_tgt  = 200;
        m_dead = 0;
        for (int i = 0; i < 30 && m_duty != -320; i++) mperiod(1'b1, -16'sd400, "rev");
        chk("at_m320", int'(duty_out), -320);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_duty", int'(duty_out), 0);
        chk("arst_state", int'(state), S_SAFE);
        chk("arst_trip", int'(wdt_trip), 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 1'b1, 16'sd0);
        chk("post_rst_arm", int'(state), S_RUN);
        period(1'b1, 16'sd100, 64, S_RUN, 0, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
